dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, SRAM word-address width (64 KiB).
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  core presents an access.
REQ-005 req_ready  out  1  controller can accept; high only in IDLE.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-008 req_op  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  misaligned-access flag, valid with rsp_valid.
REQ-013 ram_en  out  1  SRAM access strobe.
REQ-014 ram_we  out  1  SRAM write (qualified by ram_en).
REQ-015 ram_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]; upper bits ignored.
REQ-016 ram_wdata  out  32  full-word write data.
REQ-017 ram_rdata  in  32  SRAM read data, valid the cycle after ram_en with ram_we=0.

Function
REQ-018 States IDLE, RD, WAIT, WR, RESP; transition when req_valid & req_ready latches addr, wdata, op and we.
REQ-019 IDLE accept -> load or sub-word store: RD; sw: WR; otherwise stay IDLE.
REQ-020 RD drives ram_en=1, ram_we=0, ram_addr from the latched address, then goes to WAIT.
REQ-021 WAIT captures ram_rdata; a load goes to RESP, a sub-word store goes to WR.
REQ-022 WR drives ram_en=1, ram_we=1; sw writes req_wdata; sb/sh write the captured word with only the addressed byte/half replaced; next state is RESP.
REQ-023 RESP asserts rsp_valid for exactly one cycle, then goes to IDLE.
REQ-024 Latency from accept edge to rsp_valid: load 3 cycles, sw 2, sb/sh 4; no overlap, so the next accept can come at the earliest one cycle after RESP.
REQ-025 Load lane select: byte uses addr[1:0]; half uses addr[1]; op 000/001 sign-extend; 100/101 zero-extend; op[1:0]=11 or 010 returns the full word.
REQ-026 Store with op[1:0]=11 is treated as sw.
REQ-027 ram_en=0 in IDLE, WAIT and RESP; ram_addr/ram_wdata are don't-care when ram_en=0.
REQ-028 Inputs are ignored outside the accept cycle; latched values are held through completion.

Reset
REQ-029 reset low at any posedge sets state to IDLE and clears all latched fields; an in-flight access is dropped and produces no response.
REQ-030 While reset is low, ram_en, ram_we, rsp_valid, rsp_err and req_ready are 0 combinationally, so a WR state coinciding with reset performs no write.
REQ-031 After reset: req_ready=1, rsp_rdata=0, rsp_err=0.

Configuration
REQ-032 Macro DMEM_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes from IDLE straight to RESP with no RAM access, rsp_err=1 and rsp_rdata=0, so the response arrives 1 cycle after accept.
REQ-033 Macro undefined: offending low address bits are ignored (half uses addr[1], word ignores addr[1:0]) and rsp_err is tied to 0.

Verification
REQ-034 Write 0x11223344 to SRAM word 0 with sw at addr 0x0, then lw at 0x0 -> rsp_rdata=0x11223344, 3 cycles after accept.
REQ-035 sb 0xAB at addr 0x2 over word 0x11223344 -> SRAM word 0x11AB3344; lb 0x2 -> 0xFFFFFFAB; lbu 0x2 -> 0x000000AB.
REQ-036 sh 0x8001 at addr 0x6 over word 0 -> word 1 = 0x80010000; lh 0x6 -> 0xFFFF8001; lhu 0x6 -> 0x00008001.
REQ-037 reset pulsed low in the cycle the FSM is in WR for an sb -> ram_we stays 0, no rsp_valid, SRAM unchanged, and req_ready=1 next cycle.
REQ-038 lw at addr 0x3: with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0, ram_en never high; without it -> word 0 returned with rsp_err=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Purpose  : Single-outstanding data-memory controller between an RV32 core
//            load/store port and a synchronous 32-bit single-port SRAM.
//            Loads are byte/half lane-selected and sign/zero-extended.
//            Sub-word stores use a read-modify-write sequence. Word stores
//            write directly.
// Revision : 1.0  initial release
//
// Ports
//   clock       in   sole clock, all state updates on posedge
//   reset       in   synchronous, active-low reset
//   req_valid   in   core presents an access
//   req_ready   out  controller can accept (IDLE only)
//   req_addr    in   [31:0] byte address
//   req_wdata   in   [31:0] store data, LSB-aligned
//   req_op      in   [2:0]  RV32 funct3 (b/h/w/bu/hu)
//   req_we      in   1 = store, 0 = load
//   rsp_valid   out  one-cycle completion pulse
//   rsp_rdata   out  [31:0] extended load data (0 for stores/errors)
//   rsp_err     out  misaligned-access flag, valid with rsp_valid
//   ram_en      out  SRAM access strobe
//   ram_we      out  SRAM write, qualified by ram_en
//   ram_addr    out  [ADDR_W-1:0] SRAM word address
//   ram_wdata   out  [31:0] full-word SRAM write data
//   ram_rdata   in   [31:0] SRAM read data, valid the cycle after a read
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   Defined   : misaligned half/word accesses complete immediately with
//               rsp_err=1 and no SRAM access.
//   Undefined : offending low address bits are ignored, rsp_err is 0.
// ============================================================================
module dmem_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_op,
  input  logic              req_we,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_op;
  logic              r_we;
  logic [31:0]       r_word;

  logic              w_accept;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  // Address bits above the SRAM window are deliberately ignored.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  assign w_accept = req_valid & req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;
  logic w_misalign;
  // Half needs addr[0]=0; any word-class op (op[1]=1) needs addr[1:0]=0.
  assign w_misalign = ((req_op[1:0] == 2'b01) & req_addr[0]) |
                      (req_op[1] & (req_addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op    <= '0;
      r_we    <= 1'b0;
      r_word  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr[ADDR_W+1:0];
            r_wdata <= req_wdata;
            r_op    <= req_op;
            r_we    <= req_we;
`ifdef DMEM_MISALIGN_TRAP_EN
            r_err   <= w_misalign;
            if (w_misalign)
              r_state <= S_RESP;
            else
`endif
            if (req_we & req_op[1])
              r_state <= S_WR;   // full-word store skips the read
            else
              r_state <= S_RD;
          end
        end
        S_RD:   r_state <= S_WAIT;
        S_WAIT: begin
          r_word  <= ram_rdata;
          r_state <= r_we ? S_WR : S_RESP;
        end
        S_WR:   r_state <= S_RESP;
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    w_load  = 32'h0;
    w_merge = r_word;

    case (r_addr[1:0])
      2'b00:   w_byte = r_word[7:0];
      2'b01:   w_byte = r_word[15:8];
      2'b10:   w_byte = r_word[23:16];
      default: w_byte = r_word[31:24];
    endcase
    w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];

    // op[2] selects zero extension (bu/hu).
    case (r_op[1:0])
      2'b00:   w_load = {{24{w_byte[7] & ~r_op[2]}}, w_byte};
      2'b01:   w_load = {{16{w_half[15] & ~r_op[2]}}, w_half};
      default: w_load = r_word;
    endcase

    case (r_op[1:0])
      2'b00: begin
        case (r_addr[1:0])
          2'b00:   w_merge[7:0]   = r_wdata[7:0];
          2'b01:   w_merge[15:8]  = r_wdata[7:0];
          2'b10:   w_merge[23:16] = r_wdata[7:0];
          default: w_merge[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (r_addr[1])
          w_merge[31:16] = r_wdata[15:0];
        else
          w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // Control outputs are forced low while reset is asserted so that a WR
  // state coinciding with reset never reaches the SRAM.
  assign req_ready = reset & (r_state == S_IDLE);
  assign rsp_valid = reset & (r_state == S_RESP);
  assign ram_en    = reset & ((r_state == S_RD) | (r_state == S_WR));
  assign ram_we    = reset & (r_state == S_WR);
  assign ram_addr  = r_addr[ADDR_W+1:2];
  assign ram_wdata = w_merge;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? w_load : 32'h0;
`else
  assign rsp_err   = 1'b0;
  assign rsp_rdata = (rsp_valid & ~r_we) ? w_load : 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Purpose  : Self-checking bench for dmem_ctrl with an SRAM model, a
//            transaction-level reference memory and a per-cycle response
//            checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_op;
  logic              req_we;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  bit   [31:0]       ram_rdata;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_op    (req_op),
    .req_we    (req_we),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM: registered read, write on ram_en & ram_we.
  bit [31:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  bit   [31:0] ref_mem [0:DEPTH-1];
  int          vectors;
  int          errors;
  int          en_cnt;
  int          we_cnt;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction: derive the architectural result from the reference
  // memory, queue the expected response cycle, then drive and wait.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] op, input bit we);
    int          idx;
    int          lat;
    int          n;
    int          exp_en;
    int          exp_we;
    int          sh;
    bit          mis;
    logic [31:0] mask;
    logic [31:0] v;
    logic [31:0] er;
    logic        ee;

    idx = int'((addr >> 2) % DEPTH);
    sh  = op[0] ? 16 * int'(addr[1]) : 8 * int'(addr[1:0]);
    mask = (op[0] ? 32'h0000FFFF : 32'h000000FF) << sh;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (op[1:0] == 2'b01 && addr[0]) || (op[1] && addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    er = 32'h0;
    ee = 1'b0;
    if (mis) begin
      lat = 1; exp_en = 0; exp_we = 0; ee = 1'b1;
    end else if (we) begin
      if (op[1]) begin
        lat = 2; exp_en = 1; exp_we = 1;
        ref_mem[idx] = wdata;
      end else begin
        lat = 4; exp_en = 2; exp_we = 1;
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
      end
    end else begin
      lat = 3; exp_en = 1; exp_we = 0;
      if (op[1]) er = ref_mem[idx];
      else begin
        v = (ref_mem[idx] & mask) >> sh;
        if (!op[2]) begin
          if (op[0] && v[15])  v = v | 32'hFFFF0000;
          if (!op[0] && v[7])  v = v | 32'hFFFFFF00;
        end
        er = v;
      end
    end

    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_op    = op;
    req_we    = we;
    @(posedge clock);
    #1;
    // Junk on the inputs after accept must not disturb the access.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_op    = 3'($urandom);
    req_we    = 1'($urandom);
    en_cnt = 0;
    we_cnt = 0;
    q.push_back('{cyc + lat - 1, er, ee});

    n = 0;
    while (q.size() != 0 && n < 12) begin @(negedge clock); #1; n++; end
    check("rsp_timeout", q.size(), 32'h0);
    q.delete();
    check("ram_en_cycles", en_cnt, exp_en);
    check("ram_we_cycles", we_cnt, exp_we);
  endtask

  initial begin
    int rd_idx;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_op    = '0;
    req_we    = 1'b0;
    vectors   = 0;
    errors    = 0;
    en_cnt    = 0;
    we_cnt    = 0;

    // Per-cycle response checker against the queued expectations.
    fork
      forever begin
        @(negedge clock);
        en_cnt += int'(ram_en);
        we_cnt += int'(ram_en & ram_we);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          check("rsp_missing", {31'b0, rsp_valid}, 32'h1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          check("rsp_valid", {31'b0, rsp_valid}, 32'h1);
          check("rsp_rdata", rsp_rdata, q[0].rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
          void'(q.pop_front());
        end else begin
          check("rsp_valid_idle", {31'b0, rsp_valid}, 32'h0);
        end
      end
    join_none

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", {31'b0, req_ready}, 32'h0);
    check("ram_en_in_reset", {31'b0, ram_en}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", {31'b0, req_ready}, 32'h1);
    check("rdata_after_reset", rsp_rdata, 32'h0);
    check("err_after_reset", {31'b0, rsp_err}, 32'h0);

    access(32'h0, 32'h11223344, 3'b010, 1'b1);            // sw
    access(32'h0, 32'h0, 3'b010, 1'b0);                   // lw
    check("lw0_literal", last_rdata, 32'h11223344);
    access(32'h2, 32'hFFFFFFAB, 3'b000, 1'b1);            // sb
    check("sb_word_literal", mem[0], 32'h11AB3344);
    access(32'h2, 32'h0, 3'b000, 1'b0);                   // lb
    check("lb_literal", last_rdata, 32'hFFFFFFAB);
    access(32'h2, 32'h0, 3'b100, 1'b0);                   // lbu
    check("lbu_literal", last_rdata, 32'h000000AB);
    access(32'h6, 32'h12348001, 3'b001, 1'b1);            // sh
    check("sh_word_literal", mem[1], 32'h80010000);
    access(32'h6, 32'h0, 3'b001, 1'b0);                   // lh
    check("lh_literal", last_rdata, 32'hFFFF8001);
    access(32'h6, 32'h0, 3'b101, 1'b0);                   // lhu
    check("lhu_literal", last_rdata, 32'h00008001);
    access(32'h3, 32'h0, 3'b000, 1'b0);                   // lb positive
    access(32'h1, 32'h0, 3'b100, 1'b0);                   // lbu
    access(32'h0, 32'h0, 3'b001, 1'b0);                   // lh positive
    access(32'h2, 32'h0, 3'b101, 1'b0);                   // lhu upper half
    access(32'h8, 32'hCAFEF00D, 3'b011, 1'b1);            // op 011 store = sw
    access(32'h8, 32'h0, 3'b111, 1'b0);                   // op 111 load = word
    access(32'h8, 32'h0, 3'b110, 1'b0);                   // op 110 load = word
    access(32'hFFFF0010, 32'h5A5AA5A5, 3'b010, 1'b1);     // upper bits ignored
    check("high_addr_word4", mem[4], 32'h5A5AA5A5);
    access(32'h10, 32'h0, 3'b010, 1'b0);
    access(32'h3, 32'h0, 3'b010, 1'b0);                   // misaligned lw
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw3_err_literal", {31'b0, last_err}, 32'h1);
    check("lw3_rdata_literal", last_rdata, 32'h0);
`else
    check("lw3_rdata_literal", last_rdata, 32'h11AB3344);
`endif
    access(32'h1, 32'h0, 3'b001, 1'b0);                   // misaligned lh
    access(32'h5, 32'hDEADBEEF, 3'b010, 1'b1);            // misaligned sw
    access(32'h4, 32'h0, 3'b010, 1'b0);

    // Reset landing on the WR cycle of an sb must suppress the write.
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 32'h1;
    req_wdata = 32'h00000077;
    req_op    = 3'b000;
    req_we    = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("in_wr_before_reset", {31'b0, ram_we}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("reset_ram_we", {31'b0, ram_we}, 32'h0);
    check("reset_ram_en", {31'b0, ram_en}, 32'h0);
    check("reset_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_wr_reset", {31'b0, req_ready}, 32'h1);
    check("sram_unchanged", mem[0], 32'h11AB3344);
    access(32'h0, 32'h0, 3'b010, 1'b0);
    check("lw0_after_reset", last_rdata, 32'h11AB3344);

    for (int i = 0; i < 5; i++) begin
      rd_idx = i;
      check("sram_final", mem[rd_idx], ref_mem[rd_idx]);
    end

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
